// File: rtl/event_counter_regs_pkg.sv
// Shared constants, register decode and helpers for the multi-channel event counter block.
package event_counter_regs_pkg;

  localparam int unsigned OffVersion   = 0;
  localparam int unsigned OffCtrl      = 1;
  localparam int unsigned OffChEn      = 2;
  localparam int unsigned OffOvfStatus = 3;
  localparam int unsigned OffOvfMask   = 4;
  localparam int unsigned OffCntBase   = 8;

  localparam int unsigned CtrlEnableBit   = 0;
  localparam int unsigned CtrlFreezeBit   = 1;
  localparam int unsigned CtrlClearAllBit = 2;

  localparam logic [15:0] VersionMagic  = 16'h5243;
  localparam logic [7:0]  VersionRev    = 8'h02;
  localparam logic [31:0] UnmappedRdata = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    RegVersion,
    RegCtrl,
    RegChEn,
    RegOvfStatus,
    RegOvfMask,
    RegCnt,
    RegNone
  } reg_sel_e;

  function automatic logic [31:0] version_word(logic [31:0] num_ch);
    return {VersionMagic, VersionRev, num_ch[7:0]};
  endfunction

  // off is already relative to the window base; anything past the last counter is unmapped.
  function automatic reg_sel_e decode_offset(logic [31:0] off, logic [31:0] num_ch);
    if (off == OffVersion) return RegVersion;
    if (off == OffCtrl) return RegCtrl;
    if (off == OffChEn) return RegChEn;
    if (off == OffOvfStatus) return RegOvfStatus;
    if (off == OffOvfMask) return RegOvfMask;
    if (off >= OffCntBase && off < OffCntBase + num_ch) return RegCnt;
    return RegNone;
  endfunction

endpackage

// File: rtl/event_counter_regs_if.sv
// Avalon-MM register bus between the system register master and slave blocks.
interface avalon_mm_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              waitrequest;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    input  readdata,
    input  readdatavalid,
    input  waitrequest
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    output readdata,
    output readdatavalid,
    output waitrequest
  );

endinterface

// File: rtl/event_counter_regs_counter.sv
// Single event counter with clear, load, clear-on-read and wrap/saturate overflow handling.
module event_counter #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             cor,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    ovf     = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (cor) begin
      // The read returns the old value, so a same-cycle event must survive as a count of 1.
      count_d = inc ? CNT_W'(1) : '0;
    end else if (inc) begin
      if (&count_q) begin
        ovf = 1'b1;
        if (SATURATE == 0) count_d = '0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/event_counter_regs.sv
// Multi-channel event counters with enables, freeze snapshot and overflow interrupt on Avalon-MM.
module event_counter_regs
  import event_counter_regs_pkg::*;
#(
  parameter int unsigned ADDR_BASE     = 0,
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned SATURATE      = 0,
  parameter int unsigned CLEAR_ON_READ = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] msg_enter,
  avalon_mm_if.slave        reg_mm,
  output logic              irq
);

  logic [ADDR_W-1:0] off;
  logic [31:0]       off_w;
  logic [31:0]       cnt_idx;
  reg_sel_e          sel;

  logic rd_en, wr_en;
  logic ctrl_wr, chen_wr, ovf_wr, mask_wr;
  logic clear_all, freeze_start;

  logic              enable_q, freeze_q;
  logic [NUM_CH-1:0] ch_en_q;
  logic [NUM_CH-1:0] ovf_status_q, ovf_status_d;
  logic [NUM_CH-1:0] ovf_mask_q;
  logic [NUM_CH-1:0] ovf_set, cnt_hit, inc, load, cor;

  logic [NUM_CH-1:0][CNT_W-1:0] count_all, snap_all;
  logic [CNT_W-1:0]             cnt_rd;

  logic              irq_q, rdv_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  assign off     = reg_mm.address - ADDR_W'(ADDR_BASE);
  assign off_w   = 32'(off);
  assign cnt_idx = off_w - OffCntBase;
  assign sel     = decode_offset(off_w, NUM_CH);

  assign rd_en        = reg_mm.read;
  assign wr_en        = reg_mm.write;
  assign ctrl_wr      = wr_en && (sel == RegCtrl);
  assign chen_wr      = wr_en && (sel == RegChEn);
  assign ovf_wr       = wr_en && (sel == RegOvfStatus);
  assign mask_wr      = wr_en && (sel == RegOvfMask);
  assign clear_all    = ctrl_wr && reg_mm.writedata[CtrlClearAllBit];
  assign freeze_start = ctrl_wr && reg_mm.writedata[CtrlFreezeBit] && !freeze_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] snap_q;

    assign cnt_hit[g] = (sel == RegCnt) && (cnt_idx == 32'(g));
    assign inc[g]     = msg_enter[g] & ch_en_q[g] & enable_q;
    assign load[g]    = wr_en & cnt_hit[g];
    assign cor[g]     = (CLEAR_ON_READ != 0) && rd_en && cnt_hit[g] && !freeze_q;

    event_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (inc[g]),
      .clr      (clear_all),
      .load     (load[g]),
      .load_val (reg_mm.writedata[CNT_W-1:0]),
      .cor      (cor[g]),
      .count    (count_all[g]),
      .ovf      (ovf_set[g])
    );

    // Snapshot takes the value visible to the CPU in the cycle freeze is written.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        snap_q <= '0;
      end else if (freeze_start) begin
        snap_q <= count_all[g];
      end
    end

    assign snap_all[g] = snap_q;
  end

  always_comb begin
    cnt_rd = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cnt_hit[c]) cnt_rd = freeze_q ? snap_all[c] : count_all[c];
    end
  end

  always_comb begin
    rdata_d = DATA_W'(UnmappedRdata);
    unique case (sel)
      RegVersion:   rdata_d = DATA_W'(version_word(NUM_CH));
      RegCtrl: begin
        rdata_d                = '0;
        rdata_d[CtrlEnableBit] = enable_q;
        rdata_d[CtrlFreezeBit] = freeze_q;
      end
      RegChEn:      rdata_d = DATA_W'(ch_en_q);
      RegOvfStatus: rdata_d = DATA_W'(ovf_status_q);
      RegOvfMask:   rdata_d = DATA_W'(ovf_mask_q);
      RegCnt:       rdata_d = DATA_W'(cnt_rd);
      RegNone:      rdata_d = DATA_W'(UnmappedRdata);
      default:      rdata_d = DATA_W'(UnmappedRdata);
    endcase
  end

  // A fresh overflow wins over a W1C clear landing in the same cycle.
  always_comb begin
    ovf_status_d = ovf_status_q;
    if (ovf_wr) ovf_status_d = ovf_status_d & ~reg_mm.writedata[NUM_CH-1:0];
    ovf_status_d = ovf_status_d | ovf_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q     <= 1'b1;
      freeze_q     <= 1'b0;
      ch_en_q      <= '1;
      ovf_status_q <= '0;
      ovf_mask_q   <= '0;
      irq_q        <= 1'b0;
      rdv_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      if (ctrl_wr) begin
        enable_q <= reg_mm.writedata[CtrlEnableBit];
        freeze_q <= reg_mm.writedata[CtrlFreezeBit];
      end
      if (chen_wr) ch_en_q <= reg_mm.writedata[NUM_CH-1:0];
      if (mask_wr) ovf_mask_q <= reg_mm.writedata[NUM_CH-1:0];
      ovf_status_q <= ovf_status_d;
      irq_q        <= |(ovf_status_q & ovf_mask_q);
      rdv_q        <= rd_en;
      if (rd_en) rdata_q <= rdata_d;
    end
  end

  assign reg_mm.readdata      = rdata_q;
  assign reg_mm.readdatavalid = rdv_q;
  assign reg_mm.waitrequest   = 1'b0;
  assign irq                  = irq_q;

endmodule

// File: tb/tb_event_counter_regs.sv
// Drives three configurations (wrap, saturate, clear-on-read) in lockstep against a reference model.
module tb_event_counter_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  msg_enter = '0;

  logic [31:0] dut_rdata [3];
  logic        dut_rdv   [3];
  logic        dut_wait  [3];
  logic        dut_irq   [3];

  int n_assert = 0;
  int n_fail   = 0;

  avalon_mm_if #(.ADDR_W(16), .DATA_W(32)) bus_w ();
  avalon_mm_if #(.ADDR_W(16), .DATA_W(32)) bus_s ();
  avalon_mm_if #(.ADDR_W(16), .DATA_W(32)) bus_c ();

  assign bus_w.address = address;  assign bus_w.read = read;  assign bus_w.write = write;
  assign bus_s.address = address;  assign bus_s.read = read;  assign bus_s.write = write;
  assign bus_c.address = address;  assign bus_c.read = read;  assign bus_c.write = write;
  assign bus_w.writedata = writedata;
  assign bus_s.writedata = writedata;
  assign bus_c.writedata = writedata;

  assign dut_rdata[0] = bus_w.readdata;  assign dut_rdv[0] = bus_w.readdatavalid;
  assign dut_rdata[1] = bus_s.readdata;  assign dut_rdv[1] = bus_s.readdatavalid;
  assign dut_rdata[2] = bus_c.readdata;  assign dut_rdv[2] = bus_c.readdatavalid;
  assign dut_wait[0]  = bus_w.waitrequest;
  assign dut_wait[1]  = bus_s.waitrequest;
  assign dut_wait[2]  = bus_c.waitrequest;

  event_counter_regs #(
    .ADDR_BASE(0), .ADDR_W(16), .DATA_W(32), .NUM_CH(4), .CNT_W(8), .SATURATE(0),
    .CLEAR_ON_READ(0)
  ) u_wrap (
    .clk(clk), .rst_n(rst_n), .msg_enter(msg_enter), .reg_mm(bus_w), .irq(dut_irq[0])
  );

  event_counter_regs #(
    .ADDR_BASE(0), .ADDR_W(16), .DATA_W(32), .NUM_CH(4), .CNT_W(8), .SATURATE(1),
    .CLEAR_ON_READ(0)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .msg_enter(msg_enter), .reg_mm(bus_s), .irq(dut_irq[1])
  );

  event_counter_regs #(
    .ADDR_BASE(0), .ADDR_W(16), .DATA_W(32), .NUM_CH(4), .CNT_W(16), .SATURATE(0),
    .CLEAR_ON_READ(1)
  ) u_cor (
    .clk(clk), .rst_n(rst_n), .msg_enter(msg_enter), .reg_mm(bus_c), .irq(dut_irq[2])
  );

  always #5 clk = ~clk;

  // Reference model: dut 0 = 8-bit wrap, dut 1 = 8-bit saturate, dut 2 = 16-bit clear-on-read.
  int unsigned cfg_w   [3] = '{8, 8, 16};
  bit          cfg_sat [3] = '{1'b0, 1'b1, 1'b0};
  bit          cfg_cor [3] = '{1'b0, 1'b0, 1'b1};

  int unsigned m_cnt  [3][4];
  int unsigned m_snap [3][4];
  bit [3:0]    m_ovf  [3];
  bit          m_irq  [3];
  bit          m_en, m_frz;
  bit [3:0]    m_chen, m_mask;
  bit          exp_rdv;
  logic [31:0] exp_rdata [3];

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int ch = 0; ch < 4; ch++) begin
        m_cnt[d][ch]  = 0;
        m_snap[d][ch] = 0;
      end
      m_ovf[d]     = '0;
      m_irq[d]     = 1'b0;
      exp_rdata[d] = '0;
    end
    m_en    = 1'b1;
    m_frz   = 1'b0;
    m_chen  = 4'hF;
    m_mask  = '0;
    exp_rdv = 1'b0;
  endfunction

  function automatic logic [31:0] model_read(int d, int a);
    if (a == 0) return 32'h5243_0204;
    if (a == 1) return {30'd0, m_frz, m_en};
    if (a == 2) return {28'd0, m_chen};
    if (a == 3) return {28'd0, m_ovf[d]};
    if (a == 4) return {28'd0, m_mask};
    if (a >= 8 && a < 12) return m_frz ? m_snap[d][a-8] : m_cnt[d][a-8];
    return 32'hDEAD_BEEF;
  endfunction

  // Applies one clock edge worth of bus traffic and events to the model.
  function automatic void model_edge(bit rd, bit wr, int a, logic [31:0] wd, logic [3:0] ev);
    bit clr_all = wr && (a == 1) && wd[2];
    exp_rdv = rd;
    for (int d = 0; d < 3; d++) begin
      int unsigned mx = (1 << cfg_w[d]) - 1;
      bit [3:0] set = '0;
      if (rd) exp_rdata[d] = model_read(d, a);
      m_irq[d] = |(m_ovf[d] & m_mask);
      for (int ch = 0; ch < 4; ch++) begin
        bit inc = ev[ch] && m_chen[ch] && m_en;
        bit hit = (a == 8 + ch);
        if (wr && (a == 1) && wd[1] && !m_frz) m_snap[d][ch] = m_cnt[d][ch];
        if (clr_all) begin
          m_cnt[d][ch] = 0;
        end else if (wr && hit) begin
          m_cnt[d][ch] = wd & mx;
        end else if (rd && hit && cfg_cor[d] && !m_frz) begin
          m_cnt[d][ch] = inc ? 1 : 0;
        end else if (inc) begin
          if (m_cnt[d][ch] == mx) begin
            set[ch] = 1'b1;
            if (!cfg_sat[d]) m_cnt[d][ch] = 0;
          end else begin
            m_cnt[d][ch] = m_cnt[d][ch] + 1;
          end
        end
      end
      if (wr && (a == 3)) m_ovf[d] = m_ovf[d] & ~wd[3:0];
      m_ovf[d] = m_ovf[d] | set;
    end
    if (wr && (a == 1)) begin
      m_en  = wd[0];
      m_frz = wd[1];
    end
    if (wr && (a == 2)) m_chen = wd[3:0];
    if (wr && (a == 4)) m_mask = wd[3:0];
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] got,
                     input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed %h expected %h", tag, d, got, exp);
    end
  endtask

  task automatic step(input bit rd, input bit wr, input int a, input logic [31:0] wd,
                      input logic [3:0] ev);
    read      = rd;
    write     = wr;
    address   = 16'(a);
    writedata = wd;
    msg_enter = ev;
    @(posedge clk);
    model_edge(rd, wr, a, wd, ev);
    #1;
    read      = 1'b0;
    write     = 1'b0;
    msg_enter = '0;
    for (int d = 0; d < 3; d++) begin
      chk("readdatavalid", d, 32'(dut_rdv[d]), 32'(exp_rdv));
      if (exp_rdv) chk("readdata", d, dut_rdata[d], exp_rdata[d]);
      chk("irq", d, 32'(dut_irq[d]), 32'(m_irq[d]));
      chk("waitrequest", d, 32'(dut_wait[d]), 32'd0);
    end
  endtask

  task automatic rd_reg(input int a);
    step(1'b1, 1'b0, a, 32'd0, 4'h0);
  endtask

  task automatic wr_reg(input int a, input logic [31:0] wd);
    step(1'b0, 1'b1, a, wd, 4'h0);
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(read && write)) else begin
        n_fail++;
        $error("FAIL rd_wr_overlap: observed read=%0b write=%0b expected not both", read, write);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #12;
    for (int d = 0; d < 3; d++) begin
      chk("reset_readdata", d, dut_rdata[d], 32'd0);
      chk("reset_rdv", d, 32'(dut_rdv[d]), 32'd0);
      chk("reset_irq", d, 32'(dut_irq[d]), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    rd_reg(0);
    chk("version", 0, dut_rdata[0], 32'h5243_0204);
    step(1'b0, 1'b0, 0, 32'd0, 4'h0);
    rd_reg(1);
    chk("ctrl_reset", 0, dut_rdata[0], 32'h1);
    rd_reg(2);
    chk("chen_reset", 0, dut_rdata[0], 32'hF);

    wr_reg(2, 32'hB);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 0, 32'd0, {i < 5, i < 3, 1'b0, 1'b1});
    rd_reg(8);
    chk("cnt0_ten", 0, dut_rdata[0], 32'd10);
    rd_reg(10);
    chk("cnt2_disabled", 0, dut_rdata[0], 32'd0);
    rd_reg(11);
    chk("cnt3_five", 0, dut_rdata[0], 32'd5);
    wr_reg(2, 32'hF);

    wr_reg(9, 32'hFE);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 32'd0, 4'h2);
    rd_reg(9);
    chk("cnt1_wrapped", 0, dut_rdata[0], 32'h01);
    rd_reg(3);
    chk("ovf_status_wrap", 0, dut_rdata[0], 32'h2);
    wr_reg(4, 32'h2);
    step(1'b0, 1'b0, 0, 32'd0, 4'h0);
    chk("irq_raised", 0, 32'(dut_irq[0]), 32'd1);
    wr_reg(3, 32'h2);
    step(1'b0, 1'b0, 0, 32'd0, 4'h0);
    chk("irq_cleared", 0, 32'(dut_irq[0]), 32'd0);

    for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 0, 32'd0, 4'h1);
    rd_reg(8);
    chk("cnt0_saturated", 1, dut_rdata[1], 32'hFF);
    rd_reg(3);
    chk("ovf_status_sat", 1, dut_rdata[1], 32'h1);

    wr_reg(8, 32'd7);
    wr_reg(1, 32'h3);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 32'd0, 4'h1);
    rd_reg(8);
    for (int d = 0; d < 3; d++) chk("frozen_read", d, dut_rdata[d], 32'd7);
    wr_reg(1, 32'h1);
    rd_reg(8);
    for (int d = 0; d < 3; d++) chk("unfrozen_read", d, dut_rdata[d], 32'd11);

    wr_reg(8, 32'd5);
    step(1'b1, 1'b0, 8, 32'd0, 4'h1);
    chk("cor_first", 2, dut_rdata[2], 32'd5);
    rd_reg(8);
    chk("cor_second", 2, dut_rdata[2], 32'd1);
    step(1'b0, 1'b1, 1, 32'h5, 4'hF);
    for (int ch = 0; ch < 4; ch++) begin
      rd_reg(8 + ch);
      chk("clear_all_wrap", 0, dut_rdata[0], 32'd0);
      chk("clear_all_cor", 2, dut_rdata[2], 32'd0);
    end

    rd_reg(6);
    chk("unmapped_6", 0, dut_rdata[0], 32'hDEAD_BEEF);
    rd_reg(12);
    chk("unmapped_12", 0, dut_rdata[0], 32'hDEAD_BEEF);
    wr_reg(0, 32'h1234_5678);
    rd_reg(0);

    read    = 1'b1;
    address = 16'd0;
    @(posedge clk);
    model_edge(1'b1, 1'b0, 0, 32'd0, 4'h0);
    #1;
    read = 1'b0;
    chk("pre_reset_rdv", 0, 32'(dut_rdv[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) chk("midread_reset_rdv", d, 32'(dut_rdv[d]), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 0, 32'd0, 4'h0);

    for (int i = 0; i < 600; i++) begin
      int unsigned op = $urandom_range(0, 9);
      logic [3:0]  ev = 4'($urandom);
      logic [31:0] wd;
      case (op)
        4, 5: step(1'b1, 1'b0, int'($urandom_range(0, 15)), 32'd0, ev);
        6: begin
          wd = ($urandom_range(0, 1) != 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3)))
                                           : $urandom;
          step(1'b0, 1'b1, int'($urandom_range(8, 11)), wd, ev);
        end
        7: begin
          wd = {29'd0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) != 0,
                $urandom_range(0, 5) != 0};
          step(1'b0, 1'b1, 1, wd, ev);
        end
        8: step(1'b0, 1'b1, int'($urandom_range(2, 4)), $urandom, ev);
        9: step(1'b0, 1'b1, int'($urandom_range(0, 15)), $urandom, ev);
        default: step(1'b0, 1'b0, 0, 32'd0, ev);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
